// File: rtl/dram_req_sm_pkg.sv
// Shared types and sizing helpers for the per-queue DRAM request state machine.
package dram_req_sm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrCmd,
        StWrData,
        StWrDone,
        StRdCmd,
        StRdData,
        StRdDone
    } state_t;

    localparam int unsigned DEF_BLOCK_SIZE = 128;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // Counters must hold the full block size, hence one extra bit.
    function automatic int unsigned cnt_width(input int unsigned block_size);
        return clog2(block_size) + 1;
    endfunction

    localparam int unsigned DEF_CNT_W = cnt_width(DEF_BLOCK_SIZE);

endpackage

// File: rtl/dram_req_sm_rd_fifo.sv
// First-word fall-through FIFO holding one block of returned DRAM read data.
module dram_rd_fifo
    import dram_req_sm_pkg::*;
#(
    parameter int unsigned WIDTH = 144,
    parameter int unsigned DEPTH = 128
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_push  = i_wr_en && !w_full;
    assign w_pop   = i_rd_en && !o_empty;
    assign o_dout  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/dram_req_sm.sv
// Arbitrates a queue's block-write and block-read requests onto one burst-command
// port and buffers the returned read block locally.
module dram_req_sm
    import dram_req_sm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int unsigned DRAM_DATA_WIDTH = 2 * (DATA_WIDTH + CTRL_WIDTH),
    parameter int unsigned DRAM_ADDR_WIDTH = 22,
    parameter int unsigned DRAM_BLOCK_SIZE = DEF_BLOCK_SIZE
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_dram_wr_req,
    input  logic [DRAM_ADDR_WIDTH-1:0] i_dram_wr_ptr,
    input  logic                       i_dram_wr_data_vld,
    input  logic [DRAM_DATA_WIDTH-1:0] i_dram_wr_data,
    output logic                       o_dram_wr_ack,
    output logic                       o_dram_wr_full,
    output logic                       o_dram_wr_done,
    input  logic                       i_dram_rd_req,
    input  logic [DRAM_ADDR_WIDTH-1:0] i_dram_rd_ptr,
    input  logic                       i_dram_rd_en,
    output logic [DRAM_DATA_WIDTH-1:0] o_dram_rd_data,
    output logic                       o_dram_rd_ack,
    output logic                       o_dram_rd_done,
    output logic                       o_dram_rd_rdy,
    output logic                       o_dram_sm_idle,
    output logic                       o_ctrl_cmd_vld,
    output logic                       o_ctrl_cmd_rnw,
    output logic [DRAM_ADDR_WIDTH-1:0] o_ctrl_cmd_addr,
    input  logic                       i_ctrl_cmd_rdy,
    output logic [DRAM_DATA_WIDTH-1:0] o_ctrl_wr_data,
    output logic                       o_ctrl_wr_en,
    input  logic                       i_ctrl_wr_rdy,
    input  logic [DRAM_DATA_WIDTH-1:0] i_ctrl_rd_data,
    input  logic                       i_ctrl_rd_vld
);

    localparam int unsigned      CNT_W    = cnt_width(DRAM_BLOCK_SIZE);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(DRAM_BLOCK_SIZE - 1);
    localparam logic [CNT_W-1:0] BLK_SIZE = CNT_W'(DRAM_BLOCK_SIZE);

    state_t                     r_state;
    logic                       r_prio_rd;
    logic [DRAM_ADDR_WIDTH-1:0] r_addr;
    logic                       r_wr_ack;
    logic                       r_rd_ack;
    logic                       r_wr_done;
    logic                       r_rd_done;
    logic [CNT_W-1:0]           r_wr_cnt;
    logic [CNT_W-1:0]           r_rx_cnt;
    logic [CNT_W-1:0]           r_pop_cnt;
    logic                       r_rd_err;

    logic                       w_wr_accept;
    logic                       w_rd_push;
    logic                       w_rd_pop;
    logic                       w_fifo_empty;
    logic [DRAM_DATA_WIDTH-1:0] w_fifo_dout;

    assign w_wr_accept = (r_state == StWrData) && i_dram_wr_data_vld && i_ctrl_wr_rdy;
    // Only the first block-size words of the outstanding read are kept.
    assign w_rd_push   = i_ctrl_rd_vld && (r_state == StRdData) && (r_rx_cnt != BLK_SIZE);
    assign w_rd_pop    = i_dram_rd_en && !w_fifo_empty;

    dram_rd_fifo #(
        .WIDTH (DRAM_DATA_WIDTH),
        .DEPTH (DRAM_BLOCK_SIZE)
    ) u_rd_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_wr_en (w_rd_push),
        .i_din   (i_ctrl_rd_data),
        .i_rd_en (i_dram_rd_en),
        .o_dout  (w_fifo_dout),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_prio_rd <= 1'b0;
            r_addr    <= '0;
            r_wr_ack  <= 1'b0;
            r_rd_ack  <= 1'b0;
            r_wr_done <= 1'b0;
            r_rd_done <= 1'b0;
            r_wr_cnt  <= '0;
            r_rx_cnt  <= '0;
            r_pop_cnt <= '0;
            r_rd_err  <= 1'b0;
        end else begin
            r_wr_ack  <= 1'b0;
            r_rd_ack  <= 1'b0;
            r_wr_done <= 1'b0;
            r_rd_done <= 1'b0;
            if (i_ctrl_rd_vld && !w_rd_push) begin
                r_rd_err <= 1'b1;
            end
            if (w_rd_push) begin
                r_rx_cnt <= r_rx_cnt + CNT_W'(1);
            end

            unique case (r_state)
                StIdle: begin
                    if (i_dram_wr_req && (!i_dram_rd_req || !r_prio_rd)) begin
                        r_wr_ack  <= 1'b1;
                        r_addr    <= i_dram_wr_ptr;
                        r_prio_rd <= 1'b1;
                        r_state   <= StWrCmd;
                    end else if (i_dram_rd_req) begin
                        r_rd_ack  <= 1'b1;
                        r_addr    <= i_dram_rd_ptr;
                        r_prio_rd <= 1'b0;
                        r_state   <= StRdCmd;
                    end
                end
                StWrCmd: begin
                    if (i_ctrl_cmd_rdy) begin
                        r_wr_cnt <= '0;
                        r_state  <= StWrData;
                    end
                end
                StWrData: begin
                    if (w_wr_accept) begin
                        if (r_wr_cnt == BLK_LAST) begin
                            r_wr_cnt  <= '0;
                            r_wr_done <= 1'b1;
                            r_state   <= StWrDone;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                        end
                    end
                end
                StRdCmd: begin
                    if (i_ctrl_cmd_rdy) begin
                        r_rx_cnt  <= '0;
                        r_pop_cnt <= '0;
                        r_state   <= StRdData;
                    end
                end
                StRdData: begin
                    if (w_rd_pop) begin
                        if (r_pop_cnt == BLK_LAST) begin
                            r_pop_cnt <= '0;
                            r_rd_done <= 1'b1;
                            r_state   <= StRdDone;
                        end else begin
                            r_pop_cnt <= r_pop_cnt + CNT_W'(1);
                        end
                    end
                end
                StWrDone: r_state <= StIdle;
                StRdDone: r_state <= StIdle;
                default:  r_state <= StIdle;
            endcase
        end
    end

    assign o_dram_wr_ack   = r_wr_ack;
    assign o_dram_rd_ack   = r_rd_ack;
    assign o_dram_wr_done  = r_wr_done;
    assign o_dram_rd_done  = r_rd_done;
    assign o_dram_sm_idle  = (r_state == StIdle);
    assign o_dram_wr_full  = !((r_state == StWrData) && i_ctrl_wr_rdy);
    assign o_ctrl_wr_en    = w_wr_accept;
    assign o_ctrl_wr_data  = i_dram_wr_data;
    assign o_ctrl_cmd_vld  = (r_state == StWrCmd) || (r_state == StRdCmd);
    assign o_ctrl_cmd_rnw  = (r_state == StRdCmd);
    assign o_ctrl_cmd_addr = r_addr;
    assign o_dram_rd_rdy   = !w_fifo_empty;
    // Head is masked while empty so stale storage never shows on the port.
    assign o_dram_rd_data  = w_fifo_empty ? '0 : w_fifo_dout;

endmodule

// File: tb/tb_dram_req_sm.sv
// Directed bench for dram_req_sm with a transaction-level reference model checked every cycle.
module tb_dram_req_sm;

    localparam int unsigned BS  = 4;
    localparam int unsigned DDW = 144;
    localparam int unsigned DAW = 22;

    logic           clk = 1'b0;
    logic           i_reset = 1'b1;
    logic           i_dram_wr_req = 1'b0;
    logic [DAW-1:0] i_dram_wr_ptr = '0;
    logic           i_dram_wr_data_vld = 1'b0;
    logic [DDW-1:0] i_dram_wr_data = '0;
    logic           i_dram_rd_req = 1'b0;
    logic [DAW-1:0] i_dram_rd_ptr = '0;
    logic           i_dram_rd_en = 1'b0;
    logic           i_ctrl_cmd_rdy = 1'b1;
    logic           i_ctrl_wr_rdy = 1'b1;
    logic [DDW-1:0] i_ctrl_rd_data = '0;
    logic           i_ctrl_rd_vld = 1'b0;

    logic           o_dram_wr_ack, o_dram_wr_full, o_dram_wr_done;
    logic [DDW-1:0] o_dram_rd_data;
    logic           o_dram_rd_ack, o_dram_rd_done, o_dram_rd_rdy, o_dram_sm_idle;
    logic           o_ctrl_cmd_vld, o_ctrl_cmd_rnw, o_ctrl_wr_en;
    logic [DAW-1:0] o_ctrl_cmd_addr;
    logic [DDW-1:0] o_ctrl_wr_data;

    always #5 clk = ~clk;

    dram_req_sm #(
        .DATA_WIDTH      (64),
        .DRAM_ADDR_WIDTH (DAW),
        .DRAM_BLOCK_SIZE (BS)
    ) dut (
        .i_clk              (clk),
        .i_reset            (i_reset),
        .i_dram_wr_req      (i_dram_wr_req),
        .i_dram_wr_ptr      (i_dram_wr_ptr),
        .i_dram_wr_data_vld (i_dram_wr_data_vld),
        .i_dram_wr_data     (i_dram_wr_data),
        .o_dram_wr_ack      (o_dram_wr_ack),
        .o_dram_wr_full     (o_dram_wr_full),
        .o_dram_wr_done     (o_dram_wr_done),
        .i_dram_rd_req      (i_dram_rd_req),
        .i_dram_rd_ptr      (i_dram_rd_ptr),
        .i_dram_rd_en       (i_dram_rd_en),
        .o_dram_rd_data     (o_dram_rd_data),
        .o_dram_rd_ack      (o_dram_rd_ack),
        .o_dram_rd_done     (o_dram_rd_done),
        .o_dram_rd_rdy      (o_dram_rd_rdy),
        .o_dram_sm_idle     (o_dram_sm_idle),
        .o_ctrl_cmd_vld     (o_ctrl_cmd_vld),
        .o_ctrl_cmd_rnw     (o_ctrl_cmd_rnw),
        .o_ctrl_cmd_addr    (o_ctrl_cmd_addr),
        .i_ctrl_cmd_rdy     (i_ctrl_cmd_rdy),
        .o_ctrl_wr_data     (o_ctrl_wr_data),
        .o_ctrl_wr_en       (o_ctrl_wr_en),
        .i_ctrl_wr_rdy      (i_ctrl_wr_rdy),
        .i_ctrl_rd_data     (i_ctrl_rd_data),
        .i_ctrl_rd_vld      (i_ctrl_rd_vld)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [DDW-1:0] act,
                             input logic [DDW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transfer phase 0=idle 1=command 2=data 3=done.
    bit             m_valid = 1'b0;
    int             m_phase;
    bit             m_rd, m_last_rd, m_ack, m_err;
    int             m_words, m_rx;
    logic [DAW-1:0] m_addr;
    logic [DDW-1:0] m_q[$];

    task automatic model_step();
        bit pop, push_ok;
        if (i_reset) begin
            m_valid = 1'b1; m_phase = 0; m_rd = 1'b0; m_last_rd = 1'b1; m_ack = 1'b0;
            m_err = 1'b0; m_words = 0; m_rx = 0; m_addr = '0; m_q.delete();
            return;
        end
        if (!m_valid) return;
        m_ack   = 1'b0;
        pop     = (m_phase == 2) && m_rd && i_dram_rd_en && (m_q.size() != 0);
        push_ok = (m_phase == 2) && m_rd && (m_rx < BS);
        case (m_phase)
            0: begin
                if (i_dram_wr_req && (!i_dram_rd_req || m_last_rd)) begin
                    m_rd = 1'b0; m_ack = 1'b1; m_addr = i_dram_wr_ptr; m_last_rd = 1'b0; m_phase = 1;
                end else if (i_dram_rd_req) begin
                    m_rd = 1'b1; m_ack = 1'b1; m_addr = i_dram_rd_ptr; m_last_rd = 1'b1; m_phase = 1;
                end
            end
            1: if (i_ctrl_cmd_rdy) begin m_phase = 2; m_words = 0; m_rx = 0; end
            2: begin
                if (!m_rd && i_dram_wr_data_vld && i_ctrl_wr_rdy) m_words++;
                if (pop) begin void'(m_q.pop_front()); m_words++; end
                if (m_words == BS) m_phase = 3;
            end
            default: m_phase = 0;
        endcase
        if (i_ctrl_rd_vld) begin
            if (push_ok) begin m_q.push_back(i_ctrl_rd_data); m_rx++; end
            else m_err = 1'b1;
        end
    endtask

    task automatic compare();
        check_bit("idle", o_dram_sm_idle, m_phase == 0);
        check_bit("wr_ack", o_dram_wr_ack, m_ack && !m_rd);
        check_bit("rd_ack", o_dram_rd_ack, m_ack && m_rd);
        check_bit("wr_done", o_dram_wr_done, (m_phase == 3) && !m_rd);
        check_bit("rd_done", o_dram_rd_done, (m_phase == 3) && m_rd);
        check_bit("cmd_vld", o_ctrl_cmd_vld, m_phase == 1);
        check_bit("cmd_rnw", o_ctrl_cmd_rnw, (m_phase == 1) && m_rd);
        check_vec("cmd_addr", DDW'(o_ctrl_cmd_addr), DDW'(m_addr));
        check_bit("wr_full", o_dram_wr_full, !((m_phase == 2) && !m_rd && i_ctrl_wr_rdy));
        check_bit("wr_en", o_ctrl_wr_en,
                  (m_phase == 2) && !m_rd && i_dram_wr_data_vld && i_ctrl_wr_rdy);
        check_vec("wr_data", o_ctrl_wr_data, i_dram_wr_data);
        check_bit("rd_rdy", o_dram_rd_rdy, m_q.size() != 0);
        check_vec("rd_data", o_dram_rd_data, (m_q.size() != 0) ? m_q[0] : {DDW{1'b0}});
        check_bit("rd_err", dut.r_rd_err, m_err);
    endtask

    logic [DDW-1:0] wr_log[$];
    logic [DDW-1:0] pop_log[$];
    int             rd_done_cnt = 0;
    logic [DAW-1:0] cmd_addr_seen = '0;
    bit             cmd_rnw_seen = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (m_valid) compare();
            if (o_ctrl_wr_en) wr_log.push_back(o_ctrl_wr_data);
            if (i_dram_rd_en && o_dram_rd_rdy) pop_log.push_back(o_dram_rd_data);
            if (o_dram_rd_done) rd_done_cnt++;
            if (o_ctrl_cmd_vld) begin
                cmd_addr_seen = o_ctrl_cmd_addr;
                cmd_rnw_seen  = o_ctrl_cmd_rnw;
            end
        end
    end

    function automatic logic [DDW-1:0] mk(input int base, input int i);
        return {9{16'(base + i)}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input bit wr, input bit rd, input logic [DAW-1:0] wptr,
                           input logic [DAW-1:0] rptr, output bit got_wr, output bit got_rd);
        i_dram_wr_req = wr; i_dram_rd_req = rd; i_dram_wr_ptr = wptr; i_dram_rd_ptr = rptr;
        tick();
        got_wr = o_dram_wr_ack;
        got_rd = o_dram_rd_ack;
        i_dram_wr_req = 1'b0; i_dram_rd_req = 1'b0;
    endtask

    // Presents words like the queue does: a word is consumed on a cycle without wr_full.
    task automatic write_words(input logic [DDW-1:0] w[4], input int n, input bit stall);
        int idx = 0, guard = 0, st = 0;
        bit acc;
        while (idx < n && guard < 40) begin
            guard++;
            i_dram_wr_data_vld = 1'b1;
            i_dram_wr_data     = w[idx];
            if (stall && idx == 2 && st < 2) begin i_ctrl_wr_rdy = 1'b0; st++; end
            else i_ctrl_wr_rdy = 1'b1;
            @(negedge clk);
            acc = !o_dram_wr_full;
            if (!i_ctrl_wr_rdy) begin
                check_bit("stall_full", o_dram_wr_full, 1'b1);
                check_bit("stall_no_wr_en", o_ctrl_wr_en, 1'b0);
            end
            tick();
            if (acc) idx++;
        end
        check_vec("words_accepted", DDW'(idx), DDW'(n));
        i_dram_wr_data_vld = 1'b0; i_dram_wr_data = '0; i_ctrl_wr_rdy = 1'b1;
    endtask

    task automatic finish_write(input logic [DDW-1:0] w[4]);
        check_bit("wr_done_after_last", o_dram_wr_done, 1'b1);
        tick();
        check_bit("wr_done_single", o_dram_wr_done, 1'b0);
        check_bit("idle_after_wr", o_dram_sm_idle, 1'b1);
        check_vec("wr_count", DDW'(wr_log.size()), DDW'(BS));
        for (int i = 0; i < wr_log.size() && i < 4; i++) check_vec("wr_word", wr_log[i], w[i]);
    endtask

    // at[j] = cycle offset after the grant cycle on which read word j arrives (-1 unused).
    task automatic read_data(input logic [DDW-1:0] w[5], input int at[5], input int cmd_hold,
                             input int en_off_lo, input int en_off_hi);
        int k = 0;
        pop_log.delete();
        if (cmd_hold > 0) i_ctrl_cmd_rdy = 1'b0;
        while (k < 40 && !o_dram_rd_done) begin
            k++;
            tick();
            if (k >= cmd_hold) i_ctrl_cmd_rdy = 1'b1;
            i_ctrl_rd_vld  = 1'b0;
            i_ctrl_rd_data = '0;
            for (int j = 0; j < 5; j++) begin
                if (at[j] == k) begin i_ctrl_rd_vld = 1'b1; i_ctrl_rd_data = w[j]; end
            end
            i_dram_rd_en = !(k > en_off_lo && k < en_off_hi);
        end
        check_bit("rd_done_seen", o_dram_rd_done, 1'b1);
        i_dram_rd_en = 1'b0; i_ctrl_rd_vld = 1'b0; i_ctrl_rd_data = '0;
        tick();
        check_bit("rd_rdy_after_block", o_dram_rd_rdy, 1'b0);
        check_bit("idle_after_rd", o_dram_sm_idle, 1'b1);
        check_vec("pop_count", DDW'(pop_log.size()), DDW'(BS));
        for (int i = 0; i < pop_log.size() && i < 4; i++) check_vec("pop_word", pop_log[i], w[i]);
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [DDW-1:0] wa[4], wb[4], rw[5], rx[5];
        int             t3[5], t6[5];
        bit             gw, gr;
        int             done0;
        for (int i = 0; i < 4; i++) begin wa[i] = mk(16'hA0, i); wb[i] = mk(16'hB0, i); end
        for (int i = 0; i < 5; i++) begin rw[i] = mk(16'hC0, i); rx[i] = mk(16'hD0, i); end
        t3 = '{3, 4, 6, 7, -1};
        t6 = '{3, 4, 5, 6, 7};

        repeat (2) tick();
        i_reset = 1'b0;
        check_bit("rst_idle", o_dram_sm_idle, 1'b1);
        check_bit("rst_wr_full", o_dram_wr_full, 1'b1);
        check_bit("rst_cmd_vld", o_ctrl_cmd_vld, 1'b0);
        check_bit("rst_rd_rdy", o_dram_rd_rdy, 1'b0);
        check_vec("rst_rd_data", o_dram_rd_data, {DDW{1'b0}});

        // Plain write, then a write with two stalled cycles mid-block.
        wr_log.delete();
        request(1'b1, 1'b0, 22'h000040, 22'h0, gw, gr);
        check_bit("t1_wr_ack", gw, 1'b1);
        write_words(wa, 4, 1'b0);
        check_vec("t1_cmd_addr", DDW'(cmd_addr_seen), DDW'(22'h40));
        check_bit("t1_cmd_rnw", cmd_rnw_seen, 1'b0);
        finish_write(wa);

        wr_log.delete();
        request(1'b1, 1'b0, 22'h000100, 22'h0, gw, gr);
        check_bit("t2_wr_ack", gw, 1'b1);
        write_words(wb, 4, 1'b1);
        finish_write(wb);

        // Read with gapped return data and rd_en held high from the start.
        done0 = rd_done_cnt;
        request(1'b0, 1'b1, 22'h0, 22'h000080, gw, gr);
        check_bit("t3_rd_ack", gr, 1'b1);
        read_data(rw, t3, 0, 0, 0);
        check_vec("t3_cmd_addr", DDW'(cmd_addr_seen), DDW'(22'h80));
        check_bit("t3_cmd_rnw", cmd_rnw_seen, 1'b1);
        check_vec("t3_done_once", DDW'(rd_done_cnt - done0), DDW'(1));
        check_bit("t3_no_err", dut.r_rd_err, 1'b0);

        // Five returned words for a four-word block, command stalled, pops paused early.
        done0 = rd_done_cnt;
        request(1'b0, 1'b1, 22'h0, 22'h000200, gw, gr);
        check_bit("t6_rd_ack", gr, 1'b1);
        read_data(rx, t6, 2, 2, 5);
        check_vec("t6_done_once", DDW'(rd_done_cnt - done0), DDW'(1));
        check_bit("t6_err_set", dut.r_rd_err, 1'b1);

        // Arbitration from reset: write, then read, then write again.
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        wr_log.delete();
        request(1'b1, 1'b1, 22'h000300, 22'h000380, gw, gr);
        check_bit("t4_first_wr", gw, 1'b1);
        check_bit("t4_first_not_rd", gr, 1'b0);
        write_words(wa, 4, 1'b0);
        finish_write(wa);
        request(1'b1, 1'b1, 22'h000300, 22'h000380, gw, gr);
        check_bit("t4_second_rd", gr, 1'b1);
        check_bit("t4_second_not_wr", gw, 1'b0);
        read_data(rw, t3, 0, 0, 0);
        wr_log.delete();
        request(1'b1, 1'b1, 22'h000300, 22'h000380, gw, gr);
        check_bit("t4_third_wr", gw, 1'b1);
        write_words(wb, 4, 1'b0);
        finish_write(wb);

        // Reset after two accepted words abandons the write.
        wr_log.delete();
        request(1'b1, 1'b0, 22'h000400, 22'h0, gw, gr);
        write_words(wa, 2, 1'b0);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check_bit("t5_idle", o_dram_sm_idle, 1'b1);
        check_bit("t5_wr_full", o_dram_wr_full, 1'b1);
        check_bit("t5_wr_ack", o_dram_wr_ack, 1'b0);
        check_bit("t5_wr_done", o_dram_wr_done, 1'b0);
        check_bit("t5_rd_done", o_dram_rd_done, 1'b0);
        check_vec("t5_partial_words", DDW'(wr_log.size()), DDW'(2));
        wr_log.delete();
        request(1'b1, 1'b0, 22'h000440, 22'h0, gw, gr);
        check_bit("t5_new_wr_ack", gw, 1'b1);
        write_words(wb, 4, 1'b0);
        finish_write(wb);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
